// File: rtl/multicycle_control_if.sv
// Instruction/data memory request handshake bundle for the multicycle sequencer.
// The controller holds a request high until the matching ready arrives.
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with retire counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of NOP-retiring.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  multicycle_control_if.master mem,
  output logic             ir_we,
  output logic [2:0]       aluop,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_LUI    = 3'b000,
    C_AUIPC  = 3'b001,
    C_JAL    = 3'b010,
    C_BRANCH = 3'b011,
    C_LOAD   = 3'b100,
    C_STORE  = 3'b101,
    C_OPIMM  = 3'b110,
    C_OP     = 3'b111
  } cls_t;

  localparam logic [1:0] PC_4   = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_ALU = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  state_t st;
  state_t st_nxt;
  cls_t   cls;
  logic   jalr;

  cls_t   dec_cls;
  logic   dec_jalr;
  logic   dec_legal;
  logic   cls_load;

  always_comb begin
    dec_cls   = C_OP;
    dec_jalr  = 1'b0;
    dec_legal = 1'b1;
    unique case (1'b1)
      (opcode == 7'b0110111): dec_cls = C_LUI;
      (opcode == 7'b0010111): dec_cls = C_AUIPC;
      (opcode == 7'b1101111): dec_cls = C_JAL;
      (opcode == 7'b1100111): begin
        dec_cls  = C_JAL;
        dec_jalr = 1'b1;
      end
      (opcode == 7'b1100011): dec_cls = C_BRANCH;
      (opcode == 7'b0000011): dec_cls = C_LOAD;
      (opcode == 7'b0100011): dec_cls = C_STORE;
      (opcode == 7'b0010011): dec_cls = C_OPIMM;
      (opcode == 7'b0110011): dec_cls = C_OP;
      default:                dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Illegal opcodes leave the class register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls  <= C_OP;
      jalr <= 1'b0;
    end else if (cls_load) begin
      cls  <= dec_cls;
      jalr <= dec_jalr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (pc_we) begin
      instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    st_nxt       = st;
    cls_load     = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    unique case (st)
      S_IDLE: begin
        st_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_we  = 1'b1;
          st_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_load = 1'b1;
          st_nxt   = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          st_nxt = S_TRAP;
`else
          pc_we  = 1'b1;
          st_nxt = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        unique case (cls)
          C_LOAD, C_STORE: st_nxt = S_MEM;
          C_BRANCH: begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_IMM : PC_4;
            st_nxt = S_FETCH;
          end
          default: st_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (cls == C_STORE);
        if (mem.dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we  = 1'b1;
            st_nxt = S_FETCH;
          end else begin
            st_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        st_nxt = S_FETCH;
        if (cls == C_LOAD) begin
          wb_sel = WB_MEM;
        end else if (cls == C_JAL) begin
          wb_sel = WB_PC4;
          pc_sel = jalr ? PC_ALU : PC_IMM;
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        st_nxt = S_TRAP;
      end
`endif
      default: begin
        st_nxt = S_IDLE;
      end
    endcase
  end

  assign aluop = cls;
  assign state = st;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (st == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state walk, cycle counts, enables.
// Checks both NOP-retire and trap handling of illegal opcodes.
module tb_multicycle_control;
  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        ir_we;
  logic [2:0]  aluop;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [31:0] instret;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0;
  int nreq;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .br_taken (br_taken),
    .mem      (bus.master),
    .ir_we    (ir_we),
    .aluop    (aluop),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .illegal  (illegal),
    .instret  (instret),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In FETCH: present op with zero-wait ready, land in DECODE.
  task automatic fetch(input logic [6:0] op);
    chk("fetch_state", 32'(state), 32'd1);
    opcode = op;
    bus.imem_ready = 1'b1;
    #1;
    chk("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    bus.imem_ready = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 7'b0;
    br_taken = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_aluop", 32'(aluop), 32'd7);
    chk("rst_instret", instret, 32'd0);
    chk("rst_strobes", 32'({bus.imem_req, bus.dmem_req, ir_we,
        pc_we, reg_we, illegal}), 32'd0);
    chk("rst_sel", 32'({pc_sel, wb_sel}), 32'd0);

    // OP
    rst_n = 1'b1;
    tick();
    chk("op_imem_req", 32'(bus.imem_req), 32'd1);
    fetch(7'b0110011);
    chk("op_decode", 32'(state), 32'd2);
    tick();
    chk("op_exec", 32'(state), 32'd3);
    chk("op_aluop", 32'(aluop), 32'd7);
    tick();
    chk("op_wb", 32'(state), 32'd5);
    chk("op_wb_en", 32'({reg_we, pc_we}), 32'd3);
    chk("op_wb_sel", 32'({wb_sel, pc_sel}), 32'd0);
    tick();
    chk("op_refetch", 32'(state), 32'd1);
    chk("op_cycles", 32'(cyc - t0), 32'd3);
    chk("op_instret", instret, 32'd1);

    // LOAD with ready delayed three cycles
    fetch(7'b0000011);
    tick();
    tick();
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      #1;
      chk("ld_mem_state", 32'(state), 32'd4);
      chk("ld_dmem_we", 32'(bus.dmem_we), 32'd0);
      chk("ld_aluop", 32'(aluop), 32'd4);
      chk("ld_no_imem", 32'(bus.imem_req), 32'd0);
      if (bus.dmem_req) nreq++;
      tick();
    end
    bus.dmem_ready = 1'b0;
    chk("ld_req_cycles", 32'(nreq), 32'd4);
    chk("ld_wb", 32'(state), 32'd5);
    chk("ld_wb_sel", 32'(wb_sel), 32'd1);
    chk("ld_reg_we", 32'(reg_we), 32'd1);
    tick();
    chk("ld_cycles", 32'(cyc - t0), 32'd7);
    chk("ld_instret", instret, 32'd2);

    // BRANCH taken then not taken
    for (int b = 1; b >= 0; b--) begin
      fetch(7'b1100011);
      tick();
      br_taken = (b == 1);
      #1;
      chk("br_exec", 32'(state), 32'd3);
      chk("br_aluop", 32'(aluop), 32'd3);
      chk("br_pc_we", 32'(pc_we), 32'd1);
      chk("br_pc_sel", 32'(pc_sel), 32'(b));
      tick();
      br_taken = 1'b0;
      chk("br_refetch", 32'(state), 32'd1);
      chk("br_cycles", 32'(cyc - t0), 32'd2);
    end
    chk("br_instret", instret, 32'd4);

    // JALR then JAL
    fetch(7'b1100111);
    tick();
    chk("jalr_aluop", 32'(aluop), 32'd2);
    tick();
    chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
    chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    fetch(7'b1101111);
    tick();
    chk("jal_aluop", 32'(aluop), 32'd2);
    tick();
    chk("jal_wb_sel", 32'(wb_sel), 32'd2);
    chk("jal_pc_sel", 32'(pc_sel), 32'd1);
    tick();
    chk("jal_instret", instret, 32'd6);

    // STORE zero-wait
    fetch(7'b0100011);
    tick();
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    chk("st_req_we", 32'({bus.dmem_req, bus.dmem_we}), 32'd3);
    chk("st_aluop", 32'(aluop), 32'd5);
    chk("st_pc_we", 32'({pc_we, pc_sel}), 32'd4);
    tick();
    bus.dmem_ready = 1'b0;
    chk("st_cycles", 32'(cyc - t0), 32'd3);
    chk("st_instret", instret, 32'd7);

    // Illegal opcode
    fetch(7'b1111111);
`ifdef CTRL_ILLEGAL_TRAP_EN
    tick();
    chk("ill_trap", 32'(state), 32'd6);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_quiet", 32'({bus.imem_req, bus.dmem_req, pc_we,
          reg_we, ir_we}), 32'd0);
      tick();
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    chk("ill_state", 32'(state), 32'd6);
    chk("ill_instret", instret, 32'd7);
`else
    chk("ill_pc_we", 32'({pc_we, pc_sel}), 32'd4);
    chk("ill_flag", 32'(illegal), 32'd0);
    tick();
    chk("ill_refetch", 32'(state), 32'd1);
    chk("ill_instret", instret, 32'd8);
`endif

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset dropped in MEM
    fetch(7'b0000011);
    tick();
    tick();
    chk("ab_dmem_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ab_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("ab_state", 32'(state), 32'd0);
    chk("ab_instret", instret, 32'd0);
    bus.dmem_ready = 1'b1;
    tick();
    chk("ab_held", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ab_fetch", 32'(state), 32'd1);
    tick();
    chk("ab_ready_ign", 32'(state), 32'd1);
    chk("ab_no_dreq", 32'(bus.dmem_req), 32'd0);
    chk("ab_instret2", instret, 32'd0);
    bus.dmem_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
